// File: rtl/pi_ctrl_pkg.sv
// Shared types and constants for the phase-interpolator code controller.
package pi_ctrl_pkg;

  localparam int PI_CODE_W   = 11;
  localparam int PI_CODE_MOD = 2048;
  localparam int LOL_CNT     = 8;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } pi_state_e;

  // Signed accumulator must hold +/- the larger threshold with headroom.
  function automatic int acc_width(input int thresh_a, input int thresh_b);
    return $clog2((thresh_a > thresh_b) ? thresh_a : thresh_b) + 2;
  endfunction

endpackage

// File: rtl/pi_vote_acc.sv
// Signed early/late vote accumulator with symmetric threshold compare.
module pi_vote_acc
  import pi_ctrl_pkg::*;
#(
  parameter int ACC_W = 6
) (
  input  logic             CLK,
  input  logic             Rst_n,
  input  logic             vote_up,
  input  logic             vote_dn,
  input  logic             hold,
  input  logic             clear,
  input  logic [ACC_W-1:0] thresh,
  output logic             step_up,
  output logic             step_dn
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] vote;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] thresh_s;

  always_comb begin
    vote = '0;
    if (vote_up)      vote = ACC_W'(1);
    else if (vote_dn) vote = '1;
    thresh_s = $signed(thresh);
    sum      = acc + vote;
    step_up  = !hold && !clear && (sum >= thresh_s);
    step_dn  = !hold && !clear && (sum <= -thresh_s);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n)                 acc <= '0;
    else if (clear)             acc <= '0;
    else if (hold)              acc <= acc;
    else if (step_up || step_dn) acc <= '0;
    else                        acc <= sum;
  end

endmodule

// File: rtl/pi_code_ctrl.sv
// Bang-bang CDR phase-interpolator code controller with ACQUIRE/TRACK gearing.
// Optional frequency integrator enabled by macro PI_CTRL_FREQ_PATH_EN.
module pi_code_ctrl
  import pi_ctrl_pkg::*;
#(
  parameter int THRESH_ACQ = 4,
  parameter int THRESH_TRK = 16,
  parameter int STEP_ACQ   = 8,
  parameter int STEP_TRK   = 1,
  parameter int REV_LOCK   = 4
) (
  input  logic                 CLK,
  input  logic                 Rst_n,
  input  logic                 Vote_Valid,
  input  logic                 Early,
  input  logic                 Late,
  input  logic                 Freeze,
  input  logic                 Load_Code,
  input  logic [PI_CODE_W-1:0] Code_In,
  output logic [PI_CODE_W-1:0] Code,
  output logic                 Code_Upd,
  output logic                 Locked
);

  localparam int ACC_W = acc_width(THRESH_ACQ, THRESH_TRK);
  localparam int REV_W = $clog2(REV_LOCK + 1);
  localparam int RUN_W = $clog2(LOL_CNT + 1);

  pi_state_e            state, state_n;
  logic [REV_W-1:0]     rev_cnt, rev_n;
  logic [RUN_W-1:0]     run_cnt, run_n;
  logic                 dir_vld, dir_vld_n;
  logic                 dir_up, dir_up_n;
  logic                 step_up, step_dn, step, same_dir;
  logic [ACC_W-1:0]     thresh;
  logic [PI_CODE_W-1:0] step_sz, code_n;
  logic                 upd_n;

  assign thresh = (state == TRACK) ? ACC_W'(THRESH_TRK) : ACC_W'(THRESH_ACQ);

  pi_vote_acc #(.ACC_W(ACC_W)) u_acc (
    .CLK     (CLK),
    .Rst_n   (Rst_n),
    .vote_up (Vote_Valid & Early & ~Late),
    .vote_dn (Vote_Valid & Late & ~Early),
    .hold    (Freeze),
    .clear   (Load_Code),
    .thresh  (thresh),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  assign step     = step_up | step_dn;
  assign same_dir = dir_vld && (dir_up == step_up);

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ACQUIRE;
      rev_cnt <= '0;
      run_cnt <= '0;
      dir_vld <= 1'b0;
      dir_up  <= 1'b0;
    end else begin
      state   <= state_n;
      rev_cnt <= rev_n;
      run_cnt <= run_n;
      dir_vld <= dir_vld_n;
      dir_up  <= dir_up_n;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_n   = state;
    rev_n     = rev_cnt;
    run_n     = run_cnt;
    dir_vld_n = dir_vld;
    dir_up_n  = dir_up;
    if (Load_Code) begin
      state_n   = ACQUIRE;
      rev_n     = '0;
      run_n     = '0;
      dir_vld_n = 1'b0;
    end else if (step) begin
      dir_vld_n = 1'b1;
      dir_up_n  = step_up;
      if (state == ACQUIRE) begin
        if (dir_vld && !same_dir) begin
          rev_n = rev_cnt + REV_W'(1);
          if (rev_n >= REV_W'(REV_LOCK)) begin
            state_n = TRACK;
            rev_n   = '0;
            run_n   = '0;
          end
        end else begin
          rev_n = '0;
        end
      end else begin
        // Run length of consecutive equal-direction steps taken while tracking.
        run_n = same_dir ? run_cnt + RUN_W'(1) : RUN_W'(1);
        if (run_n >= RUN_W'(LOL_CNT)) begin
          state_n = ACQUIRE;
          rev_n   = '0;
          run_n   = '0;
        end
      end
    end
  end

`ifdef PI_CTRL_FREQ_PATH_EN
  logic signed [7:0] freq;
  logic [7:0]        phase, freq_mag;
  logic [8:0]        phase_sum;
  logic              extra;

  always_comb begin
    freq_mag  = freq[7] ? 8'(-freq) : 8'(freq);
    phase_sum = {1'b0, phase} + {1'b0, freq_mag};
    extra     = phase_sum[8] && !Freeze && !Load_Code;
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      freq  <= '0;
      phase <= '0;
    end else if (Load_Code) begin
      freq  <= '0;
      phase <= '0;
    end else if (!Freeze) begin
      phase <= phase_sum[7:0];
      if (step && state == TRACK) begin
        if (step_up && freq != 8'sd127)       freq <= freq + 8'sd1;
        else if (step_dn && freq != -8'sd127) freq <= freq - 8'sd1;
      end
    end
  end
`endif

  // Step size follows the post-transition state.
  always_comb begin
    step_sz = (state_n == TRACK) ? PI_CODE_W'(STEP_TRK) : PI_CODE_W'(STEP_ACQ);
    code_n  = Code;
    if (Load_Code) begin
      code_n = Code_In;
    end else begin
      if (step_up)      code_n = Code + step_sz;
      else if (step_dn) code_n = Code - step_sz;
`ifdef PI_CTRL_FREQ_PATH_EN
      if (extra) code_n = code_n + (freq[7] ? {PI_CODE_W{1'b1}} : PI_CODE_W'(1));
`endif
    end
    upd_n = (code_n != Code);
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      Code     <= '0;
      Code_Upd <= 1'b0;
    end else begin
      Code     <= code_n;
      Code_Upd <= upd_n;
    end
  end

  assign Locked = (state == TRACK);

endmodule

// File: tb/tb_pi_code_ctrl.sv
// Self-checking bench for pi_code_ctrl: directed scenarios plus randomized votes against a behavioural model.
module tb_pi_code_ctrl;

  localparam int TA = 4, TT = 16, SA = 8, ST = 1, RL = 4, LOL = 8;

  logic        CLK = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Vote_Valid = 1'b0, Early = 1'b0, Late = 1'b0;
  logic        Freeze = 1'b0, Load_Code = 1'b0;
  logic [10:0] Code_In = '0;
  logic [10:0] Code;
  logic        Code_Upd, Locked;

  always #5 CLK = ~CLK;

  pi_code_ctrl #(
    .THRESH_ACQ(TA), .THRESH_TRK(TT), .STEP_ACQ(SA), .STEP_TRK(ST), .REV_LOCK(RL)
  ) dut (
    .CLK(CLK), .Rst_n(Rst_n), .Vote_Valid(Vote_Valid), .Early(Early), .Late(Late),
    .Freeze(Freeze), .Load_Code(Load_Code), .Code_In(Code_In),
    .Code(Code), .Code_Upd(Code_Upd), .Locked(Locked)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer code mod 2048, signed vote sum, lock bookkeeping.
  int m_code, m_acc, m_last, m_rev, m_run;
  bit m_lock, m_upd;

  task automatic model_reset();
    m_code = 0; m_acc = 0; m_last = 0; m_rev = 0; m_run = 0;
    m_lock = 0; m_upd = 0;
  endtask

  task automatic model_step(input bit vv, input bit e, input bit l, input bit fr,
                            input bit ld, input int ci);
    int v, old, dir, th;
    old = m_code;
    v   = (vv && e && !l) ? 1 : ((vv && l && !e) ? -1 : 0);
    if (ld) begin
      m_code = ci; m_acc = 0; m_rev = 0; m_run = 0; m_last = 0; m_lock = 0;
    end else if (!fr) begin
      m_acc += v;
      th  = m_lock ? TT : TA;
      dir = (m_acc >= th) ? 1 : ((m_acc <= -th) ? -1 : 0);
      if (dir != 0) begin
        m_acc = 0;
        if (!m_lock) begin
          if (m_last != 0 && dir != m_last) begin
            m_rev++;
            if (m_rev >= RL) begin
              m_lock = 1; m_rev = 0; m_run = 0;
            end
          end else begin
            m_rev = 0;
          end
        end else begin
          m_run = (dir == m_last) ? m_run + 1 : 1;
          if (m_run >= LOL) begin
            m_lock = 0; m_rev = 0; m_run = 0;
          end
        end
        m_last = dir;
        m_code = ((m_code + dir * (m_lock ? ST : SA)) % 2048 + 2048) % 2048;
      end
    end
    m_upd = (m_code != old);
  endtask

  // One clock: apply inputs, advance the model, compare just after the edge.
  task automatic tick(input bit vv, input bit e, input bit l, input bit fr,
                      input bit ld, input logic [10:0] ci);
    Vote_Valid = vv; Early = e; Late = l; Freeze = fr; Load_Code = ld; Code_In = ci;
    model_step(vv, e, l, fr, ld, int'(ci));
    @(posedge CLK);
    #1;
    check("code", int'(Code), m_code);
    check("code_upd", int'(Code_Upd), int'(m_upd));
    check("locked", int'(Locked), int'(m_lock));
  endtask

  task automatic vote(input bit e, input bit l);
    tick(1'b1, e, l, 1'b0, 1'b0, 11'd0);
  endtask

  task automatic burst(input bit e, input int n);
    for (int i = 0; i < n; i++) vote(e, !e);
  endtask

  initial begin
    int upd_seen;
    int mode, len;
    bit vv, e, l, fr, ld;
    logic [10:0] ci;

    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_code", int'(Code), 0);
    check("reset_upd", int'(Code_Upd), 0);
    check("reset_locked", int'(Locked), 0);
    @(negedge CLK);
    Rst_n = 1'b1;

    // Four early votes step the code by the acquire step.
    burst(1'b1, 3);
    check("acq_before_4th", int'(Code), 0);
    vote(1'b1, 1'b0);
    check("acq_step_code", int'(Code), 8);
    check("acq_step_upd", int'(Code_Upd), 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    check("acq_upd_single", int'(Code_Upd), 0);

    // Alternating bursts: four reversals declare lock, lock step uses track size.
    burst(1'b0, 4); burst(1'b1, 4); burst(1'b0, 4);
    check("pre_lock_code", int'(Code), 0);
    check("pre_lock_locked", int'(Locked), 0);
    burst(1'b1, 4);
    check("lock_locked", int'(Locked), 1);
    check("lock_code", int'(Code), 1);
    burst(1'b1, 15);
    check("trk_before_16th", int'(Code), 1);
    vote(1'b1, 1'b0);
    check("trk_step_code", int'(Code), 2);

    // Reset mid-burst clears outputs at once and discards the partial sum.
    burst(1'b1, 3);
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_code", int'(Code), 0);
    check("async_rst_upd", int'(Code_Upd), 0);
    check("async_rst_locked", int'(Locked), 0);
    model_reset();
    @(negedge CLK);
    Rst_n = 1'b1;
    burst(1'b1, 3);
    check("post_rst_3votes", int'(Code), 0);
    vote(1'b1, 1'b0);
    check("post_rst_4votes", int'(Code), 8);

    // Early and Late together never count as a vote.
    upd_seen = 0;
    for (int i = 0; i < 100; i++) begin
      vote(1'b1, 1'b1);
      if (Code_Upd) upd_seen++;
    end
    check("both_upd_pulses", upd_seen, 0);
    check("both_code", int'(Code), 8);

    // Freeze holds, then Load_Code wins in the same cycle and clears the accumulator.
    burst(1'b1, 3);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0);
    check("freeze_code", int'(Code), 8);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 11'h5A3);
    check("load_code", int'(Code), 'h5A3);
    check("load_locked", int'(Locked), 0);
    burst(1'b1, 3);
    check("load_acc_clear", int'(Code), 'h5A3);
    vote(1'b1, 1'b0);
    check("load_then_step", int'(Code), 'h5AB);

    // Modulo-2048 wrap in both directions.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd2044);
    burst(1'b1, 4);
    check("wrap_up", int'(Code), 4);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0);
    burst(1'b0, 4);
    check("wrap_down", int'(Code), 2040);

    // Randomized bursts with occasional freeze and load.
    for (int b = 0; b < 150; b++) begin
      mode = $urandom_range(0, 2);
      len  = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(4, 60);
      for (int i = 0; i < len; i++) begin
        vv = ($urandom_range(0, 9) < 8);
        case (mode)
          0:       begin e = ($urandom_range(0, 9) < 9); l = ($urandom_range(0, 9) == 0); end
          1:       begin l = ($urandom_range(0, 9) < 9); e = ($urandom_range(0, 9) == 0); end
          default: begin e = $urandom_range(0, 1); l = $urandom_range(0, 1); end
        endcase
        fr = ($urandom_range(0, 31) == 0);
        ld = ($urandom_range(0, 255) == 0);
        ci = 11'($urandom_range(0, 2047));
        tick(vv, e, l, fr, ld, ci);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pi_code_ctrl.md
PI_CODE_CTRL -- requirements
Module: pi_code_ctrl

Interface
REQ-001 SHALL have parameter THRESH_ACQ, default 4: vote-accumulator magnitude that triggers a step in ACQUIRE.
REQ-002 SHALL have parameter THRESH_TRK, default 16: trigger magnitude in TRACK.
REQ-003 SHALL have parameter STEP_ACQ, default 8: code step size in ACQUIRE.
REQ-004 SHALL have parameter STEP_TRK, default 1: code step size in TRACK.
REQ-005 SHALL have parameter REV_LOCK, default 4: consecutive direction reversals that declare lock.
REQ-006 SHALL have port CLK, input, 1: single clock; all flops rising-edge.
REQ-007 SHALL have port Rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port Vote_Valid, input, 1: phase-detector vote qualifier.
REQ-009 SHALL have port Early, input, 1: sampling clock early; advance phase (code +).
REQ-010 SHALL have port Late, input, 1: sampling clock late; retard phase (code -).
REQ-011 SHALL have port Freeze, input, 1: hold the code and accumulator.
REQ-012 SHALL have port Load_Code, input, 1: synchronous code override.
REQ-013 SHALL have port Code_In, input, 11: override value, [10:8] octant, [7:0] fine weight.
REQ-014 SHALL have port Code, output, 11: registered PI code driving the phase mixer.
REQ-015 SHALL have port Code_Upd, output, 1: one-cycle pulse when Code changes.
REQ-016 SHALL have port Locked, output, 1: high in TRACK.

Function
REQ-017 SHALL treat a vote as +1 when Vote_Valid&Early&!Late, -1 when Vote_Valid&Late&!Early, and 0 otherwise; Early&Late together is no vote.
REQ-018 SHALL keep a signed accumulator at least clog2(max thresh)+2 bits wide that adds the vote each cycle.
REQ-019 SHALL, when the accumulator reaches +thresh of the current state, register Code+step on the next edge, clear the accumulator, and pulse Code_Upd; -thresh SHALL give Code-step.
REQ-020 SHALL give a one-cycle latency from the crossing vote to the Code change.
REQ-021 SHALL do Code arithmetic modulo 2048: 2047+1 gives 0, and 0-8 gives 2040 (wraps across octant 7 to 0).
REQ-022 SHALL implement FSM states ACQUIRE and TRACK; reset enters ACQUIRE.
REQ-023 SHALL, in ACQUIRE, count steps whose direction is opposite to the previous step, clear the count on a same-direction step, and go to TRACK when the count reaches REV_LOCK.
REQ-024 SHALL, in TRACK, return to ACQUIRE after 8 consecutive same-direction steps (loss of lock), with the reversal count cleared.
REQ-025 SHALL give Load_Code the highest priority: Code<=Code_In, accumulator cleared, reversal count cleared, state forced to ACQUIRE, Code_Upd pulses only if the value differs.
REQ-026 SHALL, under Freeze without Load_Code, ignore votes and hold Code, accumulator and state; Code_Upd SHALL stay low.
REQ-027 SHALL take the post-state step size when a threshold crossing and a state transition coincide in the same cycle.

Reset
REQ-028 SHALL, on Rst_n low, asynchronously clear Code to 0, Code_Upd to 0, Locked to 0, the accumulator and the reversal count, with state ACQUIRE.
REQ-029 SHALL discard any in-progress accumulation when reset is asserted mid-operation; the first vote after release counts from 0.

Configuration
REQ-030 SHALL add a frequency integrator when macro PI_CTRL_FREQ_PATH_EN is defined: a signed 8-bit register updated ±1 on each TRACK step.
REQ-031 SHALL, with PI_CTRL_FREQ_PATH_EN defined, have the integrator issue an extra ±1 code step every 256/|freq| cycles, saturate at ±127, and clear on reset or Load_Code.
REQ-032 SHALL, without PI_CTRL_FREQ_PATH_EN, contain no integrator, and Code SHALL change only from votes or Load_Code.

Structure
REQ-033 SHALL place the state enum, PI_CODE_W=11, PI_CODE_MOD=2048 and the loss-of-lock count 8 in package pi_ctrl_pkg.
REQ-034 SHALL use one sub-module, pi_vote_acc (accumulator plus threshold compare, with thresh as an input).

Verification
REQ-035 SHALL check: after reset, 4 Early votes -> Code 0→8 on the cycle after the 4th vote, with one Code_Upd pulse.
REQ-036 SHALL check: Code=2044 loaded, 4 Early votes -> Code=4 (wrap).
REQ-037 SHALL check: alternating 4 Early / 4 Late bursts -> Locked rises after the 4th reversal, and a further 16 Early votes step Code by 1.
REQ-038 SHALL check: Early&Late held high for 100 cycles -> Code unchanged and Code_Upd never pulses.
REQ-039 SHALL check: Freeze high during 10 Early votes, then Load_Code with 0x5A3 in the same cycle -> Code=0x5A3, state ACQUIRE, accumulator 0.
REQ-040 SHALL check: Rst_n pulsed low mid-burst after 3 votes -> outputs clear immediately, and 4 new votes are needed for the next step.
